// File: rtl/dvp_pattern_gen.sv
// Synthetic dual-exposure DVP source: VSYNC/HREF timing plus test patterns on D1 (long)
// and D2 = D1/4 (short), all registered and aligned one cycle after the (h_cnt, v_cnt) decode.
module dvp_pattern_gen #(
    parameter int H_ACTIVE     = 1280,
    parameter int H_BLANK      = 200,
    parameter int V_SYNC_LINES = 4,
    parameter int V_BACK       = 16,
    parameter int V_ACTIVE     = 720,
    parameter int V_FRONT      = 10
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  D1,
    output logic [7:0]  D2,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int H_TOTAL     = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL     = V_SYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int V_ACT_START = V_SYNC_LINES + V_BACK;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_LIM    = 12'(H_ACTIVE);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_SYNC_LIM   = 11'(V_SYNC_LINES);
    localparam logic [10:0] V_ACT_BEGIN  = 11'(V_ACT_START);
    localparam logic [10:0] V_ACT_LIM    = 11'(V_ACT_END);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] VP_SYNC   = 2'd0;
    localparam logic [1:0] VP_BACK   = 2'd1;
    localparam logic [1:0] VP_ACTIVE = 2'd2;
    localparam logic [1:0] VP_FRONT  = 2'd3;

    logic [0:0]  state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  d1_q, d1_d;
    logic [7:0]  d2_q, d2_d;

    logic        running;
    logic        frame_start;
    logic        end_of_line;
    logic        end_of_frame;
    logic [1:0]  v_phase;
    logic [7:0]  x_pix;
    logic [7:0]  y_pix;
    logic [7:0]  pattern;

    // Run control and the raster counters.
    always_comb begin
        state_d      = state_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        mode_d       = mode_q;
        frame_cnt_d  = frame_cnt_q;
        running      = (state_q == ST_RUN);
        end_of_line  = (h_cnt_q == H_LAST);
        end_of_frame = end_of_line && (v_cnt_q == V_LAST);
        frame_start  = running && (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);

        case (state_q)
            ST_IDLE: begin
                h_cnt_d = 12'd0;
                v_cnt_d = 11'd0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (end_of_line) begin
                    h_cnt_d = 12'd0;
                    v_cnt_d = end_of_frame ? 11'd0 : v_cnt_q + 11'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
                // Only leave RUN on a frame boundary so no line or frame is cut short.
                if (end_of_frame && !enable) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (frame_start) begin
            mode_d      = mode;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Vertical phase decode and pattern generation for the current counter position.
    always_comb begin
        v_phase = VP_FRONT;
        if (v_cnt_q < V_SYNC_LIM) begin
            v_phase = VP_SYNC;
        end else if (v_cnt_q < V_ACT_BEGIN) begin
            v_phase = VP_BACK;
        end else if (v_cnt_q < V_ACT_LIM) begin
            v_phase = VP_ACTIVE;
        end

        x_pix = h_cnt_q[7:0];
        y_pix = 8'(v_cnt_q - V_ACT_BEGIN);

        case (mode_q)
            2'd0:    pattern = x_pix;
            2'd1:    pattern = y_pix;
            2'd2:    pattern = (x_pix[5] ^ y_pix[5]) ? 8'hFF : 8'h00;
            default: pattern = x_pix + frame_cnt_q[7:0];
        endcase

        vsync_d = running && (v_phase == VP_SYNC);
        href_d  = running && (v_phase == VP_ACTIVE) && (h_cnt_q < H_ACT_LIM);
        d1_d    = href_d ? pattern : 8'h00;
    end

    // Short exposure is the long exposure divided by four.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_d2
            if (gi < 6) begin : g_shift
                assign d2_d[gi] = d1_d[gi + 2];
            end else begin : g_zero
                assign d2_d[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            h_cnt_q     <= 12'd0;
            v_cnt_q     <= 11'd0;
            mode_q      <= 2'd0;
            frame_cnt_q <= 16'd0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            d1_q        <= 8'h00;
            d2_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
        end
    end

    assign VSYNC     = vsync_q;
    assign HREF      = href_q;
    assign D1        = d1_q;
    assign D2        = d2_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Directed bench for dvp_pattern_gen: expected pixels are queued per frame and popped on each
// HREF-high cycle; frame timing, run control and reset behaviour are checked along the way.
module tb_dvp_pattern_gen;

    localparam int HA = 16;
    localparam int HA64 = 64;
    localparam int FRAME = 140;

    logic        pclk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic        VSYNC, HREF, busy;
    logic [7:0]  D1, D2;
    logic [15:0] frame_cnt;

    logic        en64;
    logic [1:0]  mode64;
    logic        vs64, href64, busy64;
    logic [7:0]  d1_64, d2_64;
    logic [15:0] fc64;

    logic [15:0] sb_q[$];
    logic [15:0] sb64_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_vs = -1;

    dvp_pattern_gen #(
        .H_ACTIVE(HA), .H_BLANK(4), .V_SYNC_LINES(1),
        .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
    ) dut (
        .pclk(pclk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .VSYNC(VSYNC), .HREF(HREF), .D1(D1), .D2(D2),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    dvp_pattern_gen #(
        .H_ACTIVE(HA64), .H_BLANK(4), .V_SYNC_LINES(1),
        .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)
    ) dut64 (
        .pclk(pclk), .reset_n(reset_n), .enable(en64), .mode(mode64),
        .VSYNC(vs64), .HREF(href64), .D1(d1_64), .D2(d2_64),
        .frame_cnt(fc64), .busy(busy64)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pix(input logic [1:0] m, input int x, input int y, input int fc);
        logic [7:0] r;
        case (m)
            2'd0:    r = x[7:0];
            2'd1:    r = y[7:0];
            2'd2:    r = (x[5] ^ y[5]) ? 8'hFF : 8'h00;
            default: r = x[7:0] + fc[7:0];
        endcase
        return r;
    endfunction

    task automatic push_frame(input logic [1:0] m, input int fc, input int width, input bit wide);
        logic [7:0] d;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < width; x++) begin
                d = pix(m, x, y, fc);
                if (wide) sb64_q.push_back({d, 2'b00, d[7:2]});
                else      sb_q.push_back({d, 2'b00, d[7:2]});
            end
        end
    endtask

    // One clock: sample #1 after the edge, score pixels of both instances.
    task automatic step();
        logic [15:0] e;
        @(posedge pclk);
        #1;
        cyc++;
        if (HREF === 1'b1) begin
            chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("d1", D1, e[15:8]);
                chk("d2", D2, e[7:0]);
            end
        end else begin
            chk("d1_blank", D1, 0);
            chk("d2_blank", D2, 0);
        end
        if (href64 === 1'b1) begin
            chk("sb64_nonempty", 32'(sb64_q.size() > 0), 1);
            if (sb64_q.size() > 0) begin
                e = sb64_q.pop_front();
                chk("d1_64", d1_64, e[15:8]);
                chk("d2_64", d2_64, e[7:0]);
            end
        end else begin
            chk("d1_64_blank", d1_64, 0);
        end
    endtask

    // Runs one frame window starting in the frame-start cycle (counters at 0,0).
    task automatic frame(input logic [1:0] m, input int fc,
                         input int chg_at, input logic [1:0] nm, input logic ne,
                         input int chg2_at, input logic ne2, input int stop_at);
        int   rises = 0;
        int   vsh = 0;
        int   first = -1;
        logic hp;
        push_frame(m, fc, HA, 1'b0);
        for (int j = 1; j <= FRAME; j++) begin
            hp = HREF;
            step();
            if (HREF === 1'b1 && hp !== 1'b1) begin
                rises++;
                if (first < 0) first = j;
                chk("href_rise_in_vsync", VSYNC, 0);
            end
            if (VSYNC === 1'b1) vsh++;
            if (j == 1) begin
                chk("vsync_at_start", VSYNC, 1);
                chk("frame_cnt", frame_cnt, fc);
                chk("busy_run", busy, 1);
                if (last_vs >= 0) chk("vsync_period", cyc - last_vs, FRAME);
                last_vs = cyc;
            end
            if (j == chg_at) begin
                mode = nm;
                enable = ne;
            end
            if (j == chg2_at) enable = ne2;
            if (j == stop_at) return;
        end
        chk("href_pulses", rises, 4);
        chk("vsync_cycles", vsh, 20);
        chk("first_href_edge", first, 41);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        mode    = 2'd0;
        en64    = 1'b0;
        mode64  = 2'd2;
        #1;
        chk("rst_vsync", VSYNC, 0);
        chk("rst_href", HREF, 0);
        chk("rst_d1", D1, 0);
        chk("rst_d2", D2, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        repeat (3) step();
        reset_n = 1'b1;
        step();
        step();
        chk("idle_busy", busy, 0);
        chk("idle_vsync", VSYNC, 0);

        // Start: ramp frame, mode changed to vertical ramp mid-frame.
        mode   = 2'd0;
        enable = 1'b1;
        en64   = 1'b1;
        push_frame(2'd2, 1, HA64, 1'b1);
        step();
        chk("start_busy", busy, 1);
        chk("start_vsync", VSYNC, 0);
        chk("start_busy64", busy64, 1);
        en64 = 1'b0;
        last_vs = -1;
        frame(2'd0, 1, 50, 2'd1, 1'b1, -1, 1'b0, -1);

        // Vertical ramp frames; the wide instance finishes its checkerboard frame meanwhile.
        frame(2'd1, 2, -1, 2'd0, 1'b1, -1, 1'b0, -1);
        frame(2'd1, 3, -1, 2'd0, 1'b1, -1, 1'b0, -1);
        frame(2'd1, 4, 5, 2'd0, 1'b1, -1, 1'b0, -1);
        chk("sb64_drained", sb64_q.size(), 0);
        chk("busy64_done", busy64, 0);
        chk("frame_cnt64", fc64, 1);

        // Mid-frame switch to checkerboard only takes effect next frame.
        frame(2'd0, 5, 70, 2'd2, 1'b1, -1, 1'b0, -1);
        // enable dropped then re-asserted within the frame: no gap.
        frame(2'd2, 6, 10, 2'd0, 1'b0, 60, 1'b1, -1);
        // enable dropped at cycle 30: frame completes, then idle.
        frame(2'd0, 7, 30, 2'd0, 1'b0, -1, 1'b0, -1);
        chk("stop_busy", busy, 0);
        chk("stop_vsync", VSYNC, 0);
        chk("stop_href", HREF, 0);
        chk("stop_frame_cnt", frame_cnt, 7);
        repeat (5) step();
        chk("idle_busy_after", busy, 0);
        chk("idle_vsync_after", VSYNC, 0);
        chk("idle_frame_cnt", frame_cnt, 7);

        // Reset asserted at pixel 7 of the first active line.
        enable = 1'b1;
        step();
        chk("restart_busy", busy, 1);
        last_vs = -1;
        frame(2'd0, 8, -1, 2'd0, 1'b1, -1, 1'b0, 48);
        chk("pre_reset_href", HREF, 1);
        reset_n = 1'b0;
        #2;
        chk("async_href", HREF, 0);
        chk("async_d1", D1, 0);
        chk("async_vsync", VSYNC, 0);
        chk("async_frame_cnt", frame_cnt, 0);
        chk("async_busy", busy, 0);
        sb_q.delete();
        mode = 2'd3;
        repeat (3) step();
        reset_n = 1'b1;

        // Restart with enable held high; moving ramp over frames 1 and 2.
        step();
        chk("post_reset_busy", busy, 1);
        last_vs = -1;
        frame(2'd3, 1, -1, 2'd3, 1'b1, -1, 1'b0, -1);
        frame(2'd3, 2, 30, 2'd3, 1'b0, -1, 1'b0, -1);
        chk("final_busy", busy, 0);
        chk("final_frame_cnt", frame_cnt, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
